// File: rtl/ln_vector_sequencer.sv
// Run controller for the ln unit: walks operand/expected ROMs, issues each operand, checks results.
// Optional LN_SEQ_ULP_TOL_EN: accept same-sign results within 1 ULP instead of exact equality.
//
// state | meaning
// IDLE  | after reset, waiting for start
// FETCH | rom_addr stable, ROM outputs settling
// ISSUE | operand and expected word latched, dut_start pulsed
// WAIT  | waiting for dut_ready or wait-timer terminal count
// CHECK | compare result, update counters, advance address
// DONE  | run finished, done held until next start
module ln_vector_sequencer #(
   parameter int W       = 32,
   parameter int TIMEOUT = 255
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [10:0]  num_vectors,
   output logic [9:0]   rom_addr,
   input  logic [W-1:0] rom_data,
   input  logic [W-1:0] exp_data,
   output logic         dut_start,
   output logic [W-1:0] dut_operand,
   input  logic         dut_ready,
   input  logic [W-1:0] dut_result,
   output logic         busy,
   output logic         done,
   output logic [10:0]  vec_count,
   output logic [10:0]  err_count,
   output logic         timeout_flag
);
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_CHECK, S_DONE} state_t;

   state_t       state, state_next;
   logic [10:0]  num_reg;
   logic [W-1:0] exp_reg, result_reg;
   logic [7:0]   wait_cnt;
   logic         vec_fail, result_ok, last_vec, wait_tc;

   assign last_vec  = ((vec_count + 11'd1) == num_reg);
   assign wait_tc   = (wait_cnt == 8'd0);
   assign dut_start = (state == S_ISSUE);
   assign busy      = (state == S_FETCH) || (state == S_ISSUE) ||
                      (state == S_WAIT)  || (state == S_CHECK);
   assign done      = (state == S_DONE);

`ifdef LN_SEQ_ULP_TOL_EN
   logic [W-2:0] mag_diff;
   always_comb begin
      if (result_reg[W-2:0] >= exp_reg[W-2:0])
         mag_diff = result_reg[W-2:0] - exp_reg[W-2:0];
      else
         mag_diff = exp_reg[W-2:0] - result_reg[W-2:0];
      result_ok = (result_reg[W-1] == exp_reg[W-1]) && (mag_diff <= (W-1)'(1));
   end
`else
   assign result_ok = (result_reg == exp_reg);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE, S_DONE: if (start) state_next = (num_vectors == 11'd0) ? S_DONE : S_FETCH;
         S_FETCH:        state_next = S_ISSUE;
         S_ISSUE:        state_next = S_WAIT;
         S_WAIT:         if (dut_ready || wait_tc) state_next = S_CHECK;
         S_CHECK:        state_next = last_vec ? S_DONE : S_FETCH;
         default:        state_next = S_IDLE;
      endcase
   end

   // Wait timer counts down from TIMEOUT-1 so terminal count lands on the TIMEOUT-th WAIT cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         num_reg      <= '0;
         rom_addr     <= '0;
         dut_operand  <= '0;
         exp_reg      <= '0;
         result_reg   <= '0;
         wait_cnt     <= '0;
         vec_fail     <= 1'b0;
         vec_count    <= '0;
         err_count    <= '0;
         timeout_flag <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  num_reg      <= num_vectors;
                  vec_count    <= '0;
                  err_count    <= '0;
                  timeout_flag <= 1'b0;
                  rom_addr     <= '0;
               end
            end
            S_ISSUE: begin
               dut_operand <= rom_data;
               exp_reg     <= exp_data;
               wait_cnt    <= 8'(TIMEOUT - 1);
               vec_fail    <= 1'b0;
            end
            S_WAIT: begin
               if (dut_ready) begin
                  result_reg <= dut_result;
               end else if (wait_tc) begin
                  timeout_flag <= 1'b1;
                  vec_fail     <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 8'd1;
               end
            end
            S_CHECK: begin
               vec_count <= vec_count + 11'd1;
               if (vec_fail || !result_ok) err_count <= err_count + 11'd1;
               if (!last_vec) rom_addr <= rom_addr + 10'd1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_ln_vector_sequencer.sv
// Bench for ln_vector_sequencer: ROM arrays, configurable fake ln DUT, per-cycle timeline model.
module tb_ln_vector_sequencer;
   localparam int TMO = 255;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [10:0] num_vectors = '0;
   logic [9:0]  rom_addr;
   logic [31:0] rom_data, exp_data;
   logic        dut_start;
   logic [31:0] dut_operand;
   logic        dut_ready = 1'b0;
   logic [31:0] dut_result = '0;
   logic        busy, done;
   logic [10:0] vec_count, err_count;
   logic        timeout_flag;

   ln_vector_sequencer #(.W(32), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_vectors(num_vectors),
      .rom_addr(rom_addr), .rom_data(rom_data), .exp_data(exp_data),
      .dut_start(dut_start), .dut_operand(dut_operand), .dut_ready(dut_ready),
      .dut_result(dut_result), .busy(busy), .done(done), .vec_count(vec_count),
      .err_count(err_count), .timeout_flag(timeout_flag)
   );

   always #5 clk = ~clk;

   logic [31:0] op_rom [1024];
   logic [31:0] exp_rom[1024];
   assign rom_data = op_rom[rom_addr];
   assign exp_data = exp_rom[rom_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // fake ln DUT: mode 0 echo, 1 corrupt vector idx, 2 never answer vector idx, 3 expected+1 on idx
   int resp_l = 3, resp_mode = 0, resp_idx = 0, resp_ai = 0;
   bit glitch = 1'b0;
   initial begin
      forever begin
         @(negedge clk);
         if (dut_start && rst_n) begin
            resp_ai = int'(rom_addr);
            if (glitch) begin
               dut_ready = 1'b1; dut_result = ~exp_rom[resp_ai];
               @(negedge clk); dut_ready = 1'b0;
               repeat (resp_l - 1) @(negedge clk);
            end else begin
               repeat (resp_l) @(negedge clk);
            end
            if (!(resp_mode == 2 && resp_ai == resp_idx)) begin
               dut_result = exp_rom[resp_ai];
               if (resp_mode == 1 && resp_ai == resp_idx) dut_result = dut_result ^ 32'h0080_0000;
               if (resp_mode == 3 && resp_ai == resp_idx) dut_result = dut_result + 32'd1;
               dut_ready = 1'b1;
               @(negedge clk); dut_ready = 1'b0;
            end
         end
      end
   end

   // run timeline: issue/check cycle of each vector, derived from per-vector wait lengths
   int m_iss[16], m_chk[16];
   bit m_fail[16], m_to[16];
   int m_n = 0, m_c0 = 0, m_end = 0;
   bit chk_en = 1'b0;

   int ds_cnt = 0;
   int ds_t[16];
   always @(negedge clk) begin
      if (dut_start) begin
         if (ds_cnt < 16) ds_t[ds_cnt] = cyc;
         ds_cnt = ds_cnt + 1;
      end
   end

   always @(negedge clk) begin : cmp
      int c, e_vc, e_ec, e_addr, op_idx;
      bit e_ds, e_tf;
      if (chk_en && cyc > m_c0) begin
         c = cyc; e_vc = 0; e_ec = 0; e_addr = 0; op_idx = -1; e_ds = 0; e_tf = 0;
         for (int j = 0; j < m_n; j++) begin
            if (m_iss[j] == c) e_ds = 1;
            if (m_chk[j] < c) begin
               e_vc++;
               if (m_fail[j]) e_ec++;
            end
            if (m_to[j] && m_chk[j] <= c) e_tf = 1;
            if (m_iss[j] - 1 <= c) e_addr = j;
            if (m_iss[j] < c) op_idx = j;
         end
         chk("dut_start", 64'(dut_start), 64'(e_ds));
         chk("busy", 64'(busy), 64'(c <= m_end));
         chk("done", 64'(done), 64'(c > m_end));
         chk("vec_count", 64'(vec_count), 64'(e_vc));
         chk("err_count", 64'(err_count), 64'(e_ec));
         chk("timeout_flag", 64'(timeout_flag), 64'(e_tf));
         chk("rom_addr", 64'(rom_addr), 64'(e_addr));
         if (op_idx >= 0) chk("dut_operand", 64'(dut_operand), 64'(op_rom[op_idx]));
      end
   end

   int done_cyc = 0;

   task automatic launch(input int n, input int l, input int mode, input int idx, input bit gl);
      int t, w;
      resp_l = l; resp_mode = mode; resp_idx = idx; glitch = gl;
      m_n = n; m_c0 = cyc; t = cyc + 2;
      for (int j = 0; j < n; j++) begin
         w = (mode == 2 && j == idx) ? TMO : l;
         m_iss[j] = t;
         m_chk[j] = t + w + 1;
         m_to[j] = (mode == 2 && j == idx);
`ifdef LN_SEQ_ULP_TOL_EN
         m_fail[j] = (j == idx) && (mode == 1 || mode == 2);
`else
         m_fail[j] = (j == idx) && (mode == 1 || mode == 2 || mode == 3);
`endif
         t = m_chk[j] + 2;
      end
      m_end = (n == 0) ? cyc : m_chk[n-1];
      ds_cnt = 0;
      chk_en = 1'b1;
      start = 1'b1; num_vectors = 11'(n);
      @(negedge clk);
      start = 1'b0; num_vectors = 11'd7;
   endtask

   task automatic run(input int n, input int l, input int mode, input int idx, input bit gl,
                      input bit ms);
      int lim;
      bit seen;
      launch(n, l, mode, idx, gl);
      lim = m_end - m_c0 + 4; seen = 0;
      for (int i = 0; i < lim && !seen; i++) begin
         if (done) begin
            seen = 1; done_cyc = cyc;
         end else begin
            start = ms && (i == 4);
            num_vectors = 11'd3;
            @(negedge clk);
            start = 1'b0;
         end
      end
      chk("run_completes", 64'(seen), 64'd1);
      repeat (2) @(negedge clk);
      chk_en = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         op_rom[i]  = 32'h3F80_0000 + 32'(i) * 32'h0000_1234;
         exp_rom[i] = 32'h4000_0000 + 32'(i) * 32'h0001_0101;
      end
      repeat (3) @(negedge clk);
      chk("rst_rom_addr", 64'(rom_addr), 64'd0);
      chk("rst_dut_start", 64'(dut_start), 64'd0);
      chk("rst_dut_operand", 64'(dut_operand), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_vec_count", 64'(vec_count), 64'd0);
      chk("rst_err_count", 64'(err_count), 64'd0);
      chk("rst_timeout", 64'(timeout_flag), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 4 vectors, echoing DUT, latency 3
      run(4, 3, 0, 0, 1'b0, 1'b0);
      chk("A_vec_count", 64'(vec_count), 64'd4);
      chk("A_err_count", 64'(err_count), 64'd0);
      chk("A_timeout", 64'(timeout_flag), 64'd0);
      chk("A_starts", 64'(ds_cnt), 64'd4);
      chk("A_spacing", 64'(ds_t[1] - ds_t[0]), 64'd6);
      chk("A_first_start", 64'(ds_t[0] - m_c0), 64'd2);

      // 8 vectors, vector 2 corrupted
      run(8, 2, 1, 2, 1'b0, 1'b0);
      chk("B_vec_count", 64'(vec_count), 64'd8);
      chk("B_err_count", 64'(err_count), 64'd1);

      // vector 0 never answered
      run(2, 1, 2, 0, 1'b0, 1'b0);
      chk("C_vec_count", 64'(vec_count), 64'd2);
      chk("C_err_count", 64'(err_count), 64'd1);
      chk("C_timeout", 64'(timeout_flag), 64'd1);
      chk("C_timeout_gap", 64'(ds_t[1] - ds_t[0]), 64'd258);

      // off-by-one result on vector 1
      run(4, 4, 3, 1, 1'b0, 1'b0);
`ifdef LN_SEQ_ULP_TOL_EN
      chk("D_err_count", 64'(err_count), 64'd0);
`else
      chk("D_err_count", 64'(err_count), 64'd1);
`endif

      // zero-length run
      run(0, 3, 0, 0, 1'b0, 1'b0);
      chk("E_done_latency", 64'(done_cyc - m_c0), 64'd1);
      chk("E_starts", 64'(ds_cnt), 64'd0);
      chk("E_vec_count", 64'(vec_count), 64'd0);

      // spurious ready during ISSUE and start while busy
      run(3, 3, 0, 0, 1'b1, 1'b1);
      chk("F_vec_count", 64'(vec_count), 64'd3);
      chk("F_err_count", 64'(err_count), 64'd0);
      chk("F_starts", 64'(ds_cnt), 64'd3);

      // reset during WAIT of vector 5
      launch(8, 3, 0, 0, 1'b0);
      for (int i = 0; i < 60 && cyc < m_c0 + 34; i++) @(negedge clk);
      chk("G_reached_wait", 64'(cyc - m_c0), 64'd34);
      chk_en = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("G_rom_addr", 64'(rom_addr), 64'd0);
      chk("G_dut_operand", 64'(dut_operand), 64'd0);
      chk("G_busy", 64'(busy), 64'd0);
      chk("G_done", 64'(done), 64'd0);
      chk("G_vec_count", 64'(vec_count), 64'd0);
      chk("G_err_count", 64'(err_count), 64'd0);
      chk("G_timeout", 64'(timeout_flag), 64'd0);
      chk("G_dut_start", 64'(dut_start), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("G_post_vec_count", 64'(vec_count), 64'd0);
      chk("G_post_err_count", 64'(err_count), 64'd0);
      chk("G_post_busy", 64'(busy), 64'd0);
      chk("G_post_done", 64'(done), 64'd0);
      chk("G_post_starts", 64'(ds_cnt), 64'd6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ln_vector_sequencer.md
# ln_vector_sequencer

Test-vector sequencer for the natural-logarithm unit's verification environment. It walks the operand ROM and the expected-result ROM in lockstep and issues each operand to the ln datapath with a start/ready handshake. It then compares the returned result against the expected word and accumulates pass/fail statistics. It sits between the two vector ROMs and the ln DUT and replaces hand-written stimulus loops with a synthesizable, self-checking run controller.

## Interface
- W, 32, data width of operands, results and ROM words (32 or 64)
- TIMEOUT, 255, maximum cycles to wait for dut_ready per vector (1..255)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a run (ignored while busy)
- num_vectors  in  11  vectors per run, 0..1024; sampled on accepted start
- rom_addr  out  10  address to both ROMs (combinational-read ROMs)
- rom_data  in  W  operand word at rom_addr
- exp_data  in  W  expected result word at rom_addr
- dut_start  out  1  one-cycle pulse launching the DUT
- dut_operand  out  W  registered operand, stable from ISSUE until next ISSUE
- dut_ready  in  1  DUT result-valid pulse
- dut_result  in  W  DUT result, valid with dut_ready
- busy  out  1  high from accepted start until DONE
- done  out  1  level; high in DONE until next accepted start
- vec_count  out  11  vectors completed this run
- err_count  out  11  mismatching or timed-out vectors this run
- timeout_flag  out  1  sticky; set if any vector timed out this run

## Operation
- States: IDLE, FETCH, ISSUE, WAIT, CHECK, DONE.
- IDLE/DONE + start:
  - latch num_vectors;
  - clear vec_count, err_count and timeout_flag;
  - rom_addr=0, done=0, busy=1.
  - If the latched count is 0, go to DONE directly. Otherwise go to FETCH.
- FETCH: rom_addr stable; ROM outputs settle. Next state is ISSUE.
- ISSUE:
  - dut_operand<=rom_data and exp_reg<=exp_data;
  - dut_start=1 for this cycle only;
  - clear the wait counter. Next state is WAIT.
- WAIT:
  - dut_ready=1: capture dut_result, go to CHECK.
  - Otherwise increment the wait counter. When it reaches TIMEOUT, set timeout_flag, mark the vector failed, and go to CHECK.
- CHECK:
  - vec_count+1; err_count+1 on mismatch or timeout.
  - If vec_count+1 == latched count, go to DONE (busy=0, done=1).
  - Otherwise rom_addr+1, then FETCH.
- Mismatch rule: see Configuration.
- dut_ready outside WAIT is ignored; this includes the ISSUE cycle.
- start outside IDLE/DONE is ignored.
- rom_addr wraps 1023→0 only implicitly. With num_vectors ≤ 1024 the last vector is at address 1023, and no increment follows it.
- Counters never exceed 1024, so no saturation is needed.
- rst_n low at any time: immediate return to IDLE with every output at its reset value; an in-flight DUT result is discarded.

## Timing
- Reset values: rom_addr=0, dut_start=0, dut_operand=0, busy=0, done=0, vec_count=0, err_count=0, timeout_flag=0.
- Accepted start at edge k: FETCH in cycle k+1, dut_start high in cycle k+2.
- With DUT latency L (dut_ready high L cycles after the dut_start cycle, L≥1), each vector occupies L+3 cycles: FETCH, ISSUE, L×WAIT, CHECK.
- Counts update at the end of CHECK. done and DONE follow the last CHECK by one edge.
- Timed-out vector: TIMEOUT WAIT cycles, then CHECK.
- Combinational path: rom_addr→ROM→rom_data/exp_data has one full cycle (FETCH) to settle.

## Configuration
- LN_SEQ_ULP_TOL_EN defined: a result passes when the sign bits are equal and |dut_result−expected| ≤ 1, taken as an unsigned difference of the low W−1 bits. This gives 1-ULP tolerance for the log approximation.
- Not defined: a result passes only on exact bitwise equality with the expected word.

## Test plan
- Reset mid-WAIT of vector 5 → all outputs at reset values, state IDLE; a later dut_ready produces no count change.
- num_vectors=4, DUT echoes expected with L=3 → 4 dut_start pulses at addresses 0..3, spaced 6 cycles; done with vec_count=4, err_count=0, timeout_flag=0.
- num_vectors=8, DUT corrupts vector 2 (result = expected XOR 0x00800000) → err_count=1, vec_count=8.
- DUT never responds to vector 0, TIMEOUT=255, num_vectors=2 → vector 0 spends 255 WAIT cycles; timeout_flag=1, err_count≥1, run completes with vec_count=2.
- Off-by-one result (expected+1): with LN_SEQ_ULP_TOL_EN, err_count=0; without it, err_count=1. num_vectors=0 → done one cycle after start, counts 0, no dut_start.
- start pulsed while busy, and dut_ready pulsed during ISSUE → both ignored; the run proceeds unchanged.
